// File: rtl/serial_ripple_subtractor.sv
// ============================================================================
// Module      : serial_ripple_subtractor
// Description : Bit-serial a - b - bin using one full-subtractor cell and a
//               registered borrow, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_ripple_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [WIDTH-2:0]   r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_ai;
    logic               w_bi;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_shift;
    logic               w_accept;
    logic               w_last;

    // Single full-subtractor cell fed from the operand LSBs
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_shift   = {w_d, r_res};
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == c_busy) && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_next = c_busy;
            c_busy:  if (w_last) w_state_next = c_done;
            c_done:  if (out_ready) w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == c_idle);
        out_valid = (r_state == c_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == c_busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= w_shift[WIDTH-1:1];
            if (w_last) begin
                // On the final bit the cell inputs are the operand sign bits
                r_diff <= w_shift;
                r_bout <= w_br_next;
                r_ovf  <= (w_ai != w_bi) && (w_d != w_ai);
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
// ============================================================================
// Module      : tb_serial_ripple_subtractor
// Description : Self-checking bench for serial_ripple_subtractor (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_ripple_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Returns on the falling edge just after the accept edge
    task automatic accept_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        int n;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int stall, input string nm);
        int lat;
        accept_op(ta, tb, tbin);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(W));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        for (int i = 0; i < stall; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
            chk({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_stall_ready"}, 32'(in_ready), 32'd0);
            chk({nm, "_stall_diff"}, 32'(diff), 32'(ed));
            chk({nm, "_stall_bout"}, 32'(bout), 32'(eb));
            chk({nm, "_stall_ovf"}, 32'(ovf), 32'(eo));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ta;
        logic [7:0] tb;
        logic       tbin;
        logic [8:0] full;
        int         sd;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[8] = '{8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov,
                  0, $sformatf("vec%0d", i));
        end

        // Backpressure, then an immediate follow-up operation
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 5, "bp");
        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, "bp_next");
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, "pre_rst");

        // Reset asserted during the fourth BUSY cycle
        accept_op(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_ready", 32'(in_ready), 32'd1);
        do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, "after_rst");

        // Random sweep against a 9-bit unsigned / signed integer reference
        for (int n = 0; n < 1000; n++) begin
            ta   = 8'($urandom);
            tb   = 8'($urandom);
            tbin = 1'($urandom);
            full = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
            sd   = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
            do_op(ta, tb, tbin, full[7:0], full[8], (sd > 127) || (sd < -128),
                  int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
